verdict_serializer: RTL and testbench

Downstream stage of the generated RTLola monitor (`topEntity`). It captures every cycle in which any of the monitor's output streams `a`, `b` or `c` is active and buffers the captured frame in a small FIFO. Each frame is then emitted as a 64-bit word stream (header plus active values) over a valid/ready handshake to the host or trace link. Frames that arrive while the buffer is full are dropped and counted, so the consumer can detect gaps through the sequence numbers.

---
 rtl/verdict_pkg.sv | 30 +++
 rtl/verdict_fifo.sv | 58 +++++
 rtl/verdict_serializer.sv | 189 ++++++++++++++++++
 tb/tb_verdict_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/verdict_pkg.sv
// Shared types and header layout for the verdict serializer: the captured frame,
// the output FSM states and the bit positions of the header word.
package verdict_pkg;

    localparam int MASK_W       = 3;
    localparam int WORD_W       = 64;
    localparam int SEQ_MAX_W    = 60;
    localparam int HDR_MASK_LSB = 0;
    localparam int HDR_SEQ_LSB  = 3;
    localparam int HDR_MARK_BIT = 63;

    // seq is kept at its maximum width, zero-extended, so the header can be
    // built without knowing the instance's SEQ_W.
    typedef struct packed {
        logic [MASK_W-1:0]    mask;
        logic signed [63:0]   a;
        logic signed [63:0]   b;
        logic signed [63:0]   c;
        logic [SEQ_MAX_W-1:0] seq;
    } frame_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        VAL_A,
        VAL_B,
        VAL_C
    } state_t;

endpackage

// File: rtl/verdict_fifo.sv
// Frame FIFO. Exposes the head and the entry behind it so the serializer can
// load the next header in the same cycle the current frame is popped.
module verdict_fifo
    import verdict_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  frame_t                 din,
    output frame_t                 head,
    output frame_t                 head_next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    frame_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    // A push into a full FIFO lands in the slot being freed by the same-cycle pop.
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/verdict_serializer.sv
// Captures active monitor output cycles as frames, buffers them and streams each
// frame as a header word plus the active values over a valid/ready link.
module verdict_serializer
    import verdict_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [63:0]     output_a,
    input  logic signed [63:0]     output_b,
    input  logic signed [63:0]     output_c,
    input  logic                   output_a_aktv,
    input  logic                   output_b_aktv,
    input  logic                   output_c_aktv,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    // First value state after s whose mask bit is set; IDLE when none remain.
    function automatic state_t next_after(input logic [MASK_W-1:0] m, input state_t s);
        logic [MASK_W-1:0] later;
        case (s)
            HDR:     later = 3'b111;
            VAL_A:   later = 3'b110;
            VAL_B:   later = 3'b100;
            default: later = 3'b000;
        endcase
        later = later & m;
        if (later[0]) return VAL_A;
        if (later[1]) return VAL_B;
        if (later[2]) return VAL_C;
        return IDLE;
    endfunction

    function automatic logic [WORD_W-1:0] header_word(input logic [MASK_W-1:0]    m,
                                                      input logic [SEQ_MAX_W-1:0] s);
        logic [WORD_W-1:0] w;
        w                             = '0;
        w[HDR_MARK_BIT]               = 1'b1;
        w[HDR_SEQ_LSB +: SEQ_MAX_W]   = s;
        w[HDR_MASK_LSB +: MASK_W]     = m;
        return w;
    endfunction

    logic [MASK_W-1:0] mask;
    logic [SEQ_W-1:0]  seq;
    frame_t            in_frame;
    frame_t            head;
    frame_t            head_next;
    frame_t            cur_q;
    frame_t            sel_frame;
    logic              full;
    logic              empty;
    logic              capture;
    logic              xfer;
    logic              pop;
    logic              do_push;
    logic              load;
    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] val_word;

    assign mask    = {output_c_aktv, output_b_aktv, output_a_aktv};
    assign capture = en && (mask != '0);
    assign xfer    = out_valid && out_ready && en;
    assign pop     = xfer && out_last;
    assign do_push = capture && (!full || pop);

    always_comb begin
        in_frame      = '0;
        in_frame.mask = mask;
        in_frame.a    = output_a;
        in_frame.b    = output_b;
        in_frame.c    = output_c;
        in_frame.seq  = SEQ_MAX_W'(seq);
    end

    verdict_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (do_push),
        .pop      (pop),
        .din      (in_frame),
        .head     (head),
        .head_next(head_next),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    // A new header is loaded either from the buffer or straight from the
    // capturing input, so an idle link shows the header one cycle after capture.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        sel_frame = head;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load = 1'b1;
                end else if (do_push) begin
                    load      = 1'b1;
                    sel_frame = in_frame;
                end
            end
            HDR: begin
                if (xfer) state_d = next_after(cur_q.mask, HDR);
            end
            default: begin
                if (xfer) begin
                    if (out_last) begin
                        if (fifo_level > ($clog2(DEPTH)+1)'(1)) begin
                            load      = 1'b1;
                            sel_frame = head_next;
                        end else if (do_push) begin
                            load      = 1'b1;
                            sel_frame = in_frame;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = next_after(cur_q.mask, state_q);
                    end
                end
            end
        endcase
        if (load) state_d = HDR;
    end

    always_comb begin
        val_word = '0;
        case (state_d)
            VAL_A:   val_word = cur_q.a;
            VAL_B:   val_word = cur_q.b;
            VAL_C:   val_word = cur_q.c;
            default: val_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            if (load) begin
                out_data  <= header_word(sel_frame.mask, sel_frame.seq);
                out_valid <= 1'b1;
                out_last  <= 1'b0;
            end else if (state_d != state_q) begin
                out_data  <= val_word;
                out_valid <= (state_d != IDLE);
                out_last  <= (state_d != IDLE) && (next_after(cur_q.mask, state_d) == IDLE);
            end
        end
    end

    // The frame being emitted; it stays at the FIFO head until its last word.
    always_ff @(posedge clk) begin
        if (en && load) cur_q <= sel_frame;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (capture) begin
            seq <= seq + SEQ_W'(1);
            if (full && !pop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_verdict_serializer.sv
// Randomised bench for verdict_serializer: a frame-level reference model feeds a
// word scoreboard that a separate monitor drains, plus directed scenario checks.
module tb_verdict_serializer;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [63:0] output_a, output_b, output_c;
    logic               output_a_aktv, output_b_aktv, output_c_aktv;
    logic [63:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               overflow;
    logic [15:0]        drop_count;
    logic [3:0]         fifo_level;

    verdict_serializer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_a(output_a), .output_b(output_b), .output_c(output_c),
        .output_a_aktv(output_a_aktv), .output_b_aktv(output_b_aktv), .output_c_aktv(output_c_aktv),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          stored = 0;
    int          drops_m = 0;
    bit          ov_m = 0;
    int unsigned seq_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model: frames are whole units; the buffer holds at most DEPTH of them
    // (including the one being sent), and a completing frame frees its slot at once.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            stored  = 0;
            drops_m = 0;
            ov_m    = 0;
            seq_m   = 0;
        end else begin
            logic [2:0]  m;
            logic [63:0] vals[3];
            bit          pop_now;
            pop_now = out_valid && out_ready && en && (exp_q.size() > 0) && exp_q[0].last;
            m = {output_c_aktv, output_b_aktv, output_a_aktv};
            if (en && m != 3'b000) begin
                if (stored < DEPTH || pop_now) begin
                    int n, k;
                    vals[0] = output_a; vals[1] = output_b; vals[2] = output_c;
                    exp_q.push_back('{(64'd1 << 63) | (64'(seq_m) << 3) | 64'(m), 1'b0});
                    n = $countones(m);
                    k = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (m[i]) begin
                            k++;
                            exp_q.push_back('{vals[i], k == n});
                        end
                    end
                    stored++;
                end else begin
                    drops_m++;
                    ov_m = 1;
                end
                seq_m = (seq_m + 1) % (1 << SEQ_W);
            end
            if (pop_now) stored--;
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    always begin
        bit          have_prev;
        bit          prev_valid, prev_xfer;
        logic [63:0] prev_data;
        word_t       w;
        @(negedge clk);
        #1;
        if (!rst) begin
            have_prev = 0;
        end else begin
            if (have_prev && prev_valid && !prev_xfer) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready && en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 64'hx);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", out_data, w.data);
                    check("word_last", 64'(out_last), 64'(w.last));
                end
            end
            have_prev  = 1;
            prev_valid = out_valid;
            prev_xfer  = out_valid && out_ready && en;
            prev_data  = out_data;
        end
    end

    task automatic step(input logic e, input logic [2:0] m, input logic [63:0] va,
                        input logic [63:0] vb, input logic [63:0] vc, input logic rdy);
        @(posedge clk);
        #1;
        en            = e;
        output_a_aktv = m[0];
        output_b_aktv = m[1];
        output_c_aktv = m[2];
        output_a      = va;
        output_b      = vb;
        output_c      = vc;
        out_ready     = rdy;
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 3'b000, 64'd0, 64'd0, 64'd0, rdy);
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            idle(1'b1);
            budget--;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0]  lvl0;
        logic [63:0] d0;
        rst = 1'b0;
        en = 1'b0;
        output_a = '0; output_b = '0; output_c = '0;
        output_a_aktv = 1'b0; output_b_aktv = 1'b0; output_c_aktv = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        @(negedge clk);
        #3;
        rst = 1'b1;

        // Single stream a
        step(1'b1, 3'b001, 64'd1, 64'd0, 64'd0, 1'b1);
        idle(1'b1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_header", out_data, 64'h8000_0000_0000_0001);
        check("t1_level", 64'(fifo_level), 64'd1);
        drain();

        // All three streams
        step(1'b1, 3'b111, 64'd5, -64'sd1, 64'd7, 1'b1);
        idle(1'b1);
        check("t2_header", out_data, 64'h8000_0000_0000_000F);
        drain();

        // Back-pressure on the header
        step(1'b1, 3'b110, 64'd0, 64'h1111, 64'h2222, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_header", out_data, 64'h8000_0000_0000_0016);
        end
        drain();

        // Overflow from a clean start
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++)
            step(1'b1, 3'($urandom_range(1, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, 1'b0);
        idle(1'b0);
        check("t4_level", 64'(fifo_level), 64'(DEPTH));
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_drop_count", 64'(drop_count), 64'd3);
        drain();
        step(1'b1, 3'b010, 64'd0, 64'd42, 64'd0, 1'b1);
        idle(1'b1);
        check("t4_next_seq", 64'(out_data[SEQ_W+2:3]), 64'(DEPTH + 3));
        drain();

        // Reset in the middle of a frame
        step(1'b1, 3'b011, 64'd10, 64'd20, 64'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        rst = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_data", out_data, 64'd0);
        check("t5_last", 64'(out_last), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_drop_count", 64'(drop_count), 64'd0);
        check("t5_level", 64'(fifo_level), 64'd0);
        @(negedge clk);
        #3;
        rst = 1'b1;
        step(1'b1, 3'b001, 64'd9, 64'd0, 64'd0, 1'b1);
        idle(1'b1);
        check("t5_seq0_header", out_data, 64'h8000_0000_0000_0001);
        drain();

        // Clock enable low with active strobes
        step(1'b1, 3'b100, 64'd0, 64'd0, 64'd77, 1'b0);
        idle(1'b0);
        lvl0 = fifo_level;
        d0   = out_data;
        check("t6_header", d0, 64'h8000_0000_0000_000C);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b111, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            check("t6_level_hold", 64'(fifo_level), 64'(lvl0));
            check("t6_data_hold", out_data, d0);
        end
        idle(1'b0);
        check("t6_level_hold", 64'(fifo_level), 64'(lvl0));
        check("t6_data_hold", out_data, d0);
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(1'($urandom_range(0, 9) != 0), m, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, 1'($urandom_range(0, 9) < 7));
        end
        drain();
        check("final_level", 64'(fifo_level), 64'd0);
        check("final_drop_count", 64'(drop_count), 64'(drops_m));
        check("final_overflow", 64'(overflow), 64'(ov_m));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
